// File: rtl/sp_ram_arbiter_if.sv
// Requester-side port bundle for sp_ram_arbiter: a valid/ready request channel
// plus an unconditioned read-response pulse.
interface sp_ram_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 10
);
  logic             valid;
  logic             ready;
  logic             we;
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] wdata;
  logic             rvalid;
  logic [WIDTH-1:0] rdata;

  modport master (
    output valid, we, addr, wdata,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, we, addr, wdata,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/sp_ram_arbiter.sv
// Two-requester arbiter in front of one single-port RAM, with pipelined read-response routing.
// Define SP_RAM_ARB_FIXED_PRIO_EN for fixed priority (A wins); default is round-robin.
module sp_ram_arbiter #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 1024,
  parameter int RAM_LATENCY = 1,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  sp_ram_arbiter_if.slave  a,
  sp_ram_arbiter_if.slave  b,
  output logic             ram_we,
  output logic [AW-1:0]    ram_addr,
  output logic [WIDTH-1:0] ram_din,
  input  logic [WIDTH-1:0] ram_dout
);

  generate
    if (RAM_LATENCY < 1 || RAM_LATENCY > 2) begin : g_bad_latency
      $error("sp_ram_arbiter: RAM_LATENCY must be 1 or 2");
    end
  endgenerate

  logic grant_a;
  logic grant_b;

`ifdef SP_RAM_ARB_FIXED_PRIO_EN
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!rst) begin
      grant_a = a.valid;
      grant_b = b.valid & ~a.valid;
    end
  end
`else
  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_e;

  grant_e last_grant_q;
  grant_e last_grant_d;

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!rst) begin
      if (a.valid && b.valid) begin
        grant_a = (last_grant_q == GRANT_B);
        grant_b = ~grant_a;
      end else begin
        grant_a = a.valid;
        grant_b = b.valid;
      end
    end
  end

  // Only an actual grant moves the round-robin pointer; idle cycles keep it.
  always_comb begin
    last_grant_d = last_grant_q;
    if (grant_a) begin
      last_grant_d = GRANT_A;
    end else if (grant_b) begin
      last_grant_d = GRANT_B;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= GRANT_B;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  assign a.ready = grant_a;
  assign b.ready = grant_b;

  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (grant_a) begin
      ram_we   = a.we;
      ram_addr = a.addr;
      ram_din  = a.wdata;
    end else if (grant_b) begin
      ram_we   = b.we;
      ram_addr = b.addr;
      ram_din  = b.wdata;
    end
  end

  // Tag pipe mirrors the RAM read latency; id 0 = A, 1 = B.
  logic                   push_vld;
  logic                   push_id;
  logic [RAM_LATENCY-1:0] tag_vld_q;
  logic [RAM_LATENCY-1:0] tag_vld_d;
  logic [RAM_LATENCY-1:0] tag_id_q;
  logic [RAM_LATENCY-1:0] tag_id_d;

  assign push_vld = (grant_a & ~a.we) | (grant_b & ~b.we);
  assign push_id  = grant_b;

  generate
    for (genvar gi = 0; gi < RAM_LATENCY; gi++) begin : g_tag
      if (gi == 0) begin : g_head
        assign tag_vld_d[gi] = push_vld;
        assign tag_id_d[gi]  = push_id;
      end else begin : g_shift
        assign tag_vld_d[gi] = tag_vld_q[gi-1];
        assign tag_id_d[gi]  = tag_id_q[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld_q <= '0;
      tag_id_q  <= '0;
    end else begin
      tag_vld_q <= tag_vld_d;
      tag_id_q  <= tag_id_d;
    end
  end

  // Gating with rst drops a response whose tag is still draining on the first reset cycle.
  assign a.rvalid = ~rst & tag_vld_q[RAM_LATENCY-1] & ~tag_id_q[RAM_LATENCY-1];
  assign b.rvalid = ~rst & tag_vld_q[RAM_LATENCY-1] &  tag_id_q[RAM_LATENCY-1];
  assign a.rdata  = ram_dout;
  assign b.rdata  = ram_dout;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Directed self-checking bench for sp_ram_arbiter with a behavioural single-port RAM.
// Build with SP_RAM_ARB_FIXED_PRIO_EN defined to exercise the fixed-priority contention test.
module tb_sp_ram_arbiter;
  localparam int WIDTH = 32;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int LAT   = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sp_ram_arbiter_if #(.WIDTH(WIDTH), .AW(AW)) ifa ();
  sp_ram_arbiter_if #(.WIDTH(WIDTH), .AW(AW)) ifb ();

  logic             ram_we;
  logic [AW-1:0]    ram_addr;
  logic [WIDTH-1:0] ram_din;
  logic [WIDTH-1:0] ram_dout;

  sp_ram_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RAM_LATENCY(LAT)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (ifa.slave),
    .b        (ifb.slave),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    rd1 <= mem[ram_addr];
    rd2 <= rd1;
  end
  assign ram_dout = (LAT == 2) ? rd2 : rd1;

  int errors = 0;
  int checks = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic mid;
    @(negedge clk);
  endtask

  task automatic idle_inputs;
    ifa.valid = 1'b0; ifa.we = 1'b0; ifa.addr = '0; ifa.wdata = '0;
    ifb.valid = 1'b0; ifb.we = 1'b0; ifb.addr = '0; ifb.wdata = '0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    ifa.valid = 1'b1; ifa.we = 1'b1; ifa.addr = 10'd3; ifa.wdata = 32'h1234_5678;
    ifb.valid = 1'b1; ifb.we = 1'b0; ifb.addr = 10'd4; ifb.wdata = '0;
    for (int c = 0; c < 3; c++) begin
      tick;
      mid;
      checks++;
      if ({ifa.ready, ifb.ready, ram_we} !== 3'b000) begin
        errors++;
        $display("FAIL reset_ready cyc%0d: a_ready=%b b_ready=%b ram_we=%b expected 0 0 0",
                 c, ifa.ready, ifb.ready, ram_we);
      end
      checks++;
      if ({ifa.rvalid, ifb.rvalid} !== 2'b00) begin
        errors++;
        $display("FAIL reset_rvalid cyc%0d: a_rvalid=%b b_rvalid=%b expected 0 0",
                 c, ifa.rvalid, ifb.rvalid);
      end
      checks++;
      if (ram_addr !== 10'd0) begin
        errors++;
        $display("FAIL reset_addr cyc%0d: ram_addr=%0d expected 0", c, ram_addr);
      end
    end
    tick;
    rst = 1'b0;
    idle_inputs();
    tick;
    $display("test_reset done");
  endtask

  task automatic test_write_read;
    ifa.valid = 1'b1; ifa.we = 1'b1; ifa.addr = 10'd5; ifa.wdata = 32'hDEAD_BEEF;
    mid;
    checks++;
    if ({ifa.ready, ifb.ready, ram_we} !== 3'b101 || ram_addr !== 10'd5 || ram_din !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL wr_grant: a_ready=%b b_ready=%b we=%b addr=%0d din=%h expected 1 0 1 5 deadbeef",
               ifa.ready, ifb.ready, ram_we, ram_addr, ram_din);
    end
    tick;
    ifa.we = 1'b0;
    mid;
    checks++;
    if ({ifa.ready, ram_we} !== 2'b10 || ram_addr !== 10'd5 || {ifa.rvalid, ifb.rvalid} !== 2'b00) begin
      errors++;
      $display("FAIL rd_grant: a_ready=%b we=%b addr=%0d rv=%b%b expected 1 0 5 00",
               ifa.ready, ram_we, ram_addr, ifa.rvalid, ifb.rvalid);
    end
    tick;
    ifa.valid = 1'b0;
    for (int k = 1; k <= LAT + 1; k++) begin
      mid;
      checks++;
      if (ifa.rvalid !== (k == LAT) || ifb.rvalid !== 1'b0) begin
        errors++;
        $display("FAIL rd_resp k=%0d: a_rvalid=%b b_rvalid=%b expected %b 0",
                 k, ifa.rvalid, ifb.rvalid, (k == LAT));
      end
      if (k == LAT) begin
        checks++;
        if (ifa.rdata !== 32'hDEAD_BEEF) begin
          errors++;
          $display("FAIL rd_data: a_rdata=%h expected deadbeef", ifa.rdata);
        end
      end
      tick;
    end
    $display("test_write_read done");
  endtask

  task automatic test_back_to_back;
    logic             exp_v  [16];
    logic             exp_id [16];
    logic [WIDTH-1:0] exp_d  [16];
    int               a_cnt;
    int               b_cnt;
    logic             exp_b;
    for (int i = 0; i < 16; i++) begin
      exp_v[i] = 1'b0; exp_id[i] = 1'b0; exp_d[i] = '0;
    end
    for (int i = 0; i < 8; i++) begin
      ifa.valid = 1'b1; ifa.we = 1'b1;
      ifa.addr  = (i < 4) ? AW'(1 + i) : AW'(7 + i);
      ifa.wdata = 32'hC000_0000 | 32'(ifa.addr);
      tick;
    end
    idle_inputs();
    ifa.valid = 1'b1; ifa.we = 1'b0; ifa.addr = 10'd1;
    ifb.valid = 1'b1; ifb.we = 1'b0; ifb.addr = 10'd11;
    a_cnt = 0;
    b_cnt = 0;
    // Preload was all-A, so B wins the first contended cycle.
    for (int c = 0; c < 8 + LAT + 1; c++) begin
      mid;
      if (c < 8) begin
        exp_b = ((c % 2) == 0);
        checks++;
        if (ifa.ready !== ~exp_b || ifb.ready !== exp_b) begin
          errors++;
          $display("FAIL b2b_grant cyc%0d: a_ready=%b b_ready=%b expected %b %b",
                   c, ifa.ready, ifb.ready, ~exp_b, exp_b);
        end
        exp_v[c + LAT]  = 1'b1;
        exp_id[c + LAT] = exp_b;
        exp_d[c + LAT]  = 32'hC000_0000 | 32'(exp_b ? ifb.addr : ifa.addr);
      end
      if (c >= LAT) begin
        checks++;
        if (ifa.rvalid !== (exp_v[c] & ~exp_id[c]) || ifb.rvalid !== (exp_v[c] & exp_id[c])) begin
          errors++;
          $display("FAIL b2b_rvalid cyc%0d: a_rvalid=%b b_rvalid=%b expected %b %b",
                   c, ifa.rvalid, ifb.rvalid, exp_v[c] & ~exp_id[c], exp_v[c] & exp_id[c]);
        end
        if (exp_v[c]) begin
          checks++;
          if (ram_dout !== exp_d[c] || ifa.rdata !== exp_d[c] || ifb.rdata !== exp_d[c]) begin
            errors++;
            $display("FAIL b2b_rdata cyc%0d: a_rdata=%h b_rdata=%h expected %h",
                     c, ifa.rdata, ifb.rdata, exp_d[c]);
          end
        end
      end
      tick;
      if (c < 8) begin
        if (exp_b) begin
          b_cnt++;
          if (b_cnt == 4) ifb.valid = 1'b0; else ifb.addr = ifb.addr + 1'b1;
        end else begin
          a_cnt++;
          if (a_cnt == 4) ifa.valid = 1'b0; else ifa.addr = ifa.addr + 1'b1;
        end
      end
    end
    idle_inputs();
    $display("test_back_to_back done");
  endtask

  task automatic test_write_then_read;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    ifa.valid = 1'b1; ifa.we = 1'b1; ifa.addr = 10'd7; ifa.wdata = 32'h11;
    ifb.valid = 1'b1; ifb.we = 1'b0; ifb.addr = 10'd7;
    mid;
    checks++;
    if ({ifa.ready, ifb.ready, ram_we} !== 3'b101 || ram_din !== 32'h11) begin
      errors++;
      $display("FAIL raw_first: a_ready=%b b_ready=%b we=%b din=%h expected 1 0 1 11",
               ifa.ready, ifb.ready, ram_we, ram_din);
    end
    tick;
    ifa.valid = 1'b0;
    mid;
    checks++;
    if ({ifa.ready, ifb.ready, ram_we} !== 3'b010 || ram_addr !== 10'd7) begin
      errors++;
      $display("FAIL raw_second: a_ready=%b b_ready=%b we=%b addr=%0d expected 0 1 0 7",
               ifa.ready, ifb.ready, ram_we, ram_addr);
    end
    tick;
    ifb.valid = 1'b0;
    for (int k = 1; k <= LAT + 1; k++) begin
      mid;
      checks++;
      if (ifb.rvalid !== (k == LAT) || ifa.rvalid !== 1'b0) begin
        errors++;
        $display("FAIL raw_resp k=%0d: a_rvalid=%b b_rvalid=%b expected 0 %b",
                 k, ifa.rvalid, ifb.rvalid, (k == LAT));
      end
      if (k == LAT) begin
        checks++;
        if (ifb.rdata !== 32'h11) begin
          errors++;
          $display("FAIL raw_data: b_rdata=%h expected 11", ifb.rdata);
        end
      end
      tick;
    end
    idle_inputs();
    $display("test_write_then_read done");
  endtask

  task automatic test_reset_flush;
    ifa.valid = 1'b1; ifa.we = 1'b0; ifa.addr = 10'd1;
    mid;
    checks++;
    if (ifa.ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_issue: a_ready=%b expected 1", ifa.ready);
    end
    tick;
    rst = 1'b1;
    ifa.valid = 1'b0;
    ifb.valid = 1'b1; ifb.we = 1'b0; ifb.addr = 10'd2;
    for (int c = 0; c < 2; c++) begin
      mid;
      checks++;
      if ({ifa.ready, ifb.ready, ifa.rvalid, ifb.rvalid} !== 4'b0000) begin
        errors++;
        $display("FAIL flush_in_reset cyc%0d: ready=%b%b rvalid=%b%b expected 0000",
                 c, ifa.ready, ifb.ready, ifa.rvalid, ifb.rvalid);
      end
      tick;
    end
    rst = 1'b0;
    idle_inputs();
    for (int c = 0; c < 4; c++) begin
      mid;
      checks++;
      if ({ifa.rvalid, ifb.rvalid} !== 2'b00) begin
        errors++;
        $display("FAIL flush_after cyc%0d: a_rvalid=%b b_rvalid=%b expected 0 0",
                 c, ifa.rvalid, ifb.rvalid);
      end
      tick;
    end
    ifa.valid = 1'b1; ifa.we = 1'b0; ifa.addr = 10'd3;
    ifb.valid = 1'b1; ifb.we = 1'b0; ifb.addr = 10'd4;
    mid;
    checks++;
    if ({ifa.ready, ifb.ready} !== 2'b10) begin
      errors++;
      $display("FAIL flush_contend: a_ready=%b b_ready=%b expected 1 0", ifa.ready, ifb.ready);
    end
    tick;
    ifa.valid = 1'b0;
    tick;
    ifb.valid = 1'b0;
    repeat (LAT + 1) tick;
    $display("test_reset_flush done");
  endtask

  task automatic test_contention;
    ifa.valid = 1'b1; ifa.we = 1'b0; ifa.addr = 10'd1;
    ifb.valid = 1'b1; ifb.we = 1'b0; ifb.addr = 10'd11;
`ifdef SP_RAM_ARB_FIXED_PRIO_EN
    for (int c = 0; c < 10; c++) begin
      mid;
      checks++;
      if ({ifa.ready, ifb.ready} !== 2'b10) begin
        errors++;
        $display("FAIL fixed_prio cyc%0d: a_ready=%b b_ready=%b expected 1 0",
                 c, ifa.ready, ifb.ready);
      end
      tick;
    end
    ifa.valid = 1'b0;
    mid;
    checks++;
    if (ifb.ready !== 1'b1) begin
      errors++;
      $display("FAIL fixed_release: b_ready=%b expected 1", ifb.ready);
    end
    tick;
`else
    // Last grant before this test went to B, so A leads the alternation.
    for (int c = 0; c < 10; c++) begin
      mid;
      checks++;
      if (ifa.ready !== ((c % 2) == 0) || ifb.ready !== ((c % 2) == 1)) begin
        errors++;
        $display("FAIL rr_alternate cyc%0d: a_ready=%b b_ready=%b expected %b %b",
                 c, ifa.ready, ifb.ready, ((c % 2) == 0), ((c % 2) == 1));
      end
      tick;
    end
`endif
    idle_inputs();
    repeat (LAT + 1) tick;
    $display("test_contention done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_write_read();
    test_back_to_back();
    test_write_then_read();
    test_reset_flush();
    test_contention();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
